// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   localparam int DATA_BITS    = 8;
   localparam int CLKS_PER_BIT = 4;
   localparam int STOP_BITS    = 1;

   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/shift_reg_par_in_serial_out.sv
// Parallel-load, serial-out shift register; bit 0 is the next bit to leave.
module shift_reg_par_in_serial_out #(
   parameter int M = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [M-1:0] byte_in,
   input  logic         shift,
   output logic         bit_out
);

   logic [M-1:0] sr;

   always_ff @(posedge clk) begin
      if (reset) begin
         sr <= '0;
      end else if (load) begin
         sr <= byte_in;
      end else if (shift) begin
         sr <= {1'b0, sr[M-1:1]};
      end
   end

   assign bit_out = sr[0];

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one start bit, M data bits LSB first, STOP_BITS stop bits.
//
//   state | meaning
//   IDLE  | line high, ready for a byte
//   START | start bit (low) held for CLKS_PER_BIT clocks
//   DATA  | data bits, LSB first, CLKS_PER_BIT clocks each
//   STOP  | stop bits (high), STOP_BITS*CLKS_PER_BIT clocks
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int M            = DATA_BITS,
   parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
   parameter int STOP_BITS    = uart_pkg::STOP_BITS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [M-1:0] byte_in,
   input  logic         valid_in,
   output logic         ready_out,
   output logic         bit_out,
   output logic         done_out
);

   localparam int TW = $clog2(CLKS_PER_BIT * STOP_BITS);
   localparam int IW = $clog2(M + 1);

   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(CLKS_PER_BIT * STOP_BITS - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(M - 1);

   uart_tx_state_t state, state_nx;
   logic [TW-1:0]  timer, timer_nx;
   logic [IW-1:0]  bit_idx, bit_idx_nx;
   logic           load, shift, sr_bit;
   logic           bit_out_nx, done_nx, ready_nx;

   shift_reg_par_in_serial_out #(.M(M)) u_sr (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .byte_in (byte_in),
      .shift   (shift),
      .bit_out (sr_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         bit_idx   <= '0;
         bit_out   <= LINE_IDLE;
         ready_out <= 1'b1;
         done_out  <= 1'b0;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         bit_idx   <= bit_idx_nx;
         bit_out   <= bit_out_nx;
         ready_out <= ready_nx;
         done_out  <= done_nx;
      end
   end

   // bit_out is registered from the next-state value; the register shifts as
   // each data bit is copied into bit_out, so it always holds the upcoming bit.
   always_comb begin
      state_nx   = state;
      timer_nx   = timer + 1'b1;
      bit_idx_nx = bit_idx;
      load       = 1'b0;
      shift      = 1'b0;
      bit_out_nx = bit_out;
      done_nx    = 1'b0;
      case (state)
         IDLE: begin
            timer_nx   = '0;
            bit_out_nx = LINE_IDLE;
            if (valid_in) begin
               load       = 1'b1;
               state_nx   = START;
               bit_out_nx = ~LINE_IDLE;
            end
         end
         START: begin
            if (timer == BIT_LAST) begin
               state_nx   = DATA;
               timer_nx   = '0;
               shift      = 1'b1;
               bit_out_nx = sr_bit;
            end
         end
         DATA: begin
            if (timer == BIT_LAST) begin
               timer_nx = '0;
               if (bit_idx == IDX_LAST) begin
                  state_nx   = STOP;
                  bit_idx_nx = '0;
                  bit_out_nx = LINE_IDLE;
               end else begin
                  bit_idx_nx = bit_idx + 1'b1;
                  shift      = 1'b1;
                  bit_out_nx = sr_bit;
               end
            end
         end
         STOP: begin
            if (timer == STOP_LAST) begin
               state_nx = IDLE;
               timer_nx = '0;
               done_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            timer_nx = '0;
         end
      endcase
      ready_nx = (state_nx == IDLE);
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter against a frame-level line model.
module tb_uart_transmitter;

   localparam int CPB       = 4;
   localparam int NB        = 8;
   localparam int SB        = 1;
   localparam int FRAME_LEN = (1 + NB + SB) * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] byte_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out, bit_out, done_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_transmitter #(.M(NB), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
      .clk       (clk),
      .reset     (reset),
      .byte_in   (byte_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .bit_out   (bit_out),
      .done_out  (done_out)
   );

   // Expected line level k cycles after the acceptance edge (k = 1..FRAME_LEN+1).
   function automatic logic exp_line(input logic [7:0] b, input int k);
      if (k <= CPB) return 1'b0;
      if (k <= (1 + NB) * CPB) return b[(k - CPB - 1) / CPB];
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready_out !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      if (ready_out !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready timeout got=%b exp=1", ready_out);
      end
   endtask

   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         checks++;
         if (bit_out !== 1'b1) begin
            errors++;
            $display("FAIL idle_line cyc=%0d got=%b exp=1", cyc, bit_out);
         end
         checks++;
         if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready cyc=%0d got=%b exp=1", cyc, ready_out);
         end
         checks++;
         if (done_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_done cyc=%0d got=%b exp=0", cyc, done_out);
         end
      end
   endtask

   // Sends b and checks every cycle up to and including the done cycle.
   // hold keeps valid_in high afterwards with next_b on byte_in.
   task automatic send_and_check(input logic [7:0] b, input bit perturb,
                                 input bit hold, input logic [7:0] next_b,
                                 output int t_start);
      wait_ready();
      byte_in  = b;
      valid_in = 1'b1;
      step();
      t_start = cyc;
      if (hold) byte_in = next_b;
      else valid_in = 1'b0;
      for (int k = 1; k <= FRAME_LEN + 1; k++) begin
         checks++;
         if (bit_out !== exp_line(b, k)) begin
            errors++;
            $display("FAIL frame_line byte=%h k=%0d got=%b exp=%b", b, k, bit_out, exp_line(b, k));
         end
         checks++;
         if (done_out !== (k == FRAME_LEN + 1)) begin
            errors++;
            $display("FAIL frame_done byte=%h k=%0d got=%b exp=%b", b, k, done_out, (k == FRAME_LEN + 1));
         end
         checks++;
         if (ready_out !== (k == FRAME_LEN + 1)) begin
            errors++;
            $display("FAIL frame_ready byte=%h k=%0d got=%b exp=%b", b, k, ready_out, (k == FRAME_LEN + 1));
         end
         if (perturb && k >= CPB + 1 && k <= (1 + NB) * CPB) begin
            valid_in = 1'($urandom_range(0, 1));
            byte_in  = 8'hFF;
         end
         if (perturb && k == (1 + NB) * CPB + 1) valid_in = 1'b0;
         if (k <= FRAME_LEN) step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if (bit_out !== 1'b1 || ready_out !== 1'b1 || done_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_values got=%b%b%b exp=110", bit_out, ready_out, done_out);
      end
      reset = 1'b0;
      idle_check(20);
   endtask

   task automatic test_basic();
      int t;
      send_and_check(8'h55, 1'b0, 1'b0, 8'h00, t);
      idle_check(3);
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      send_and_check(8'hA3, 1'b0, 1'b1, 8'h0F, t1);
      send_and_check(8'h0F, 1'b0, 1'b0, 8'h00, t2);
      checks++;
      if (t2 - t1 !== FRAME_LEN + 1) begin
         errors++;
         $display("FAIL b2b_gap got=%0d exp=%0d", t2 - t1, FRAME_LEN + 1);
      end
      idle_check(3);
   endtask

   task automatic test_ignore_midframe();
      int t;
      send_and_check(8'h3C, 1'b1, 1'b0, 8'h00, t);
      idle_check(5);
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b = 8'h81;
      wait_ready();
      byte_in  = b;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int k = 1; k <= 3 * CPB + CPB + 1; k++) step();
      checks++;
      if (bit_out !== b[3]) begin
         errors++;
         $display("FAIL abort_prebit got=%b exp=%b", bit_out, b[3]);
      end
      reset = 1'b1;
      step();
      checks++;
      if (bit_out !== 1'b1 || ready_out !== 1'b1 || done_out !== 1'b0) begin
         errors++;
         $display("FAIL abort_values got=%b%b%b exp=110", bit_out, ready_out, done_out);
      end
      reset = 1'b0;
      idle_check(FRAME_LEN);
      test_basic_byte(8'h7E);
   endtask

   task automatic test_basic_byte(input logic [7:0] b);
      int t;
      send_and_check(b, 1'b0, 1'b0, 8'h00, t);
   endtask

   task automatic test_random();
      int t;
      logic [7:0] b;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         idle_check($urandom_range(0, 3));
         send_and_check(b, 1'b0, 1'b0, 8'h00, t);
      end
      idle_check(2);
   endtask

   // Receiver-style decode: find the start edge, sample each bit at its centre.
   task automatic test_loopback();
      logic [7:0] vals [3] = '{8'h00, 8'hFF, 8'hA3};
      logic       line [FRAME_LEN];
      logic [7:0] got;
      int         n;
      for (int v = 0; v < 3; v++) begin
         wait_ready();
         byte_in  = vals[v];
         valid_in = 1'b1;
         step();
         valid_in = 1'b0;
         n = 0;
         while (bit_out !== 1'b0 && n < 10) begin
            step();
            n++;
         end
         for (int i = 0; i < FRAME_LEN; i++) begin
            line[i] = bit_out;
            step();
         end
         for (int i = 0; i < NB; i++) got[i] = line[CPB * (1 + i) + CPB / 2];
         checks++;
         if (line[CPB / 2] !== 1'b0 || line[CPB * (1 + NB) + CPB / 2] !== 1'b1) begin
            errors++;
            $display("FAIL loop_framing byte=%h start=%b stop=%b", vals[v], line[CPB / 2], line[CPB * (1 + NB) + CPB / 2]);
         end
         checks++;
         if (got !== vals[v]) begin
            errors++;
            $display("FAIL loop_byte got=%h exp=%h", got, vals[v]);
         end
         checks++;
         if (done_out !== 1'b1) begin
            errors++;
            $display("FAIL loop_done byte=%h got=%b exp=1", vals[v], done_out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_midframe();
      test_reset_mid_frame();
      test_random();
      test_loopback();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
